// File: rtl/pkt_src_rr_arbiter.sv
// Packet-atomic round-robin arbiter: one source holds the grant until its
// terminating beat transfers, with a single registered output beat stage.

package pkt_src_rr_arbiter_pkg;

  typedef struct packed {
    logic sop;
    logic eop;
  } pkt_ctl_default_t;

  typedef struct packed {
    logic [31:0] payload;
    logic [3:0]  flags;
  } pkt_data_default_t;

endpackage

// state  | meaning
// S_IDLE | no grant held; arbitrate among requesters starting at rr_ptr
// S_BUSY | grant held by one source until its terminating beat is accepted
module pkt_src_rr_arbiter
  import pkt_src_rr_arbiter_pkg::*;
#(
  parameter type pkt_data_t = pkt_data_default_t,
  parameter type pkt_ctl_t  = pkt_ctl_default_t,
  parameter int  NUM_SRC    = 4,
  parameter int  MAX_BEATS  = 64,
  localparam int ID_W       = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  pkt_ctl_t  [NUM_SRC-1:0]   src_ctl,
  input  pkt_data_t [NUM_SRC-1:0]   src_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output pkt_ctl_t                  out_ctl,
  output pkt_data_t                 out_data,
  output logic [ID_W-1:0]           out_src_id,
  output logic                      grant_busy,
  output logic                      trunc_err,
  output logic [31:0]               pkt_count
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant;
  logic [CNT_W-1:0] beat_cnt;

  logic             out_free;
  logic             accept;
  logic             cur_eop;
  logic             wdog_hit;
  logic             term_beat;
  logic             trunc_now;
  logic [ID_W-1:0]  pick;
  logic             pick_found;
  logic [ID_W-1:0]  next_ptr;
  pkt_ctl_t         ctl_mux;

  assign out_free   = !out_valid || out_ready;
  assign accept     = (state == S_BUSY) && src_valid[grant] && out_free;
  assign cur_eop    = src_ctl[grant].eop;
  assign wdog_hit   = (beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign term_beat  = accept && (cur_eop || wdog_hit);
  assign trunc_now  = accept && wdog_hit && !cur_eop;
  assign next_ptr   = (grant == ID_W'(NUM_SRC - 1)) ? '0 : grant + ID_W'(1);
  assign grant_busy = (state == S_BUSY);

  always_comb begin
    src_ready = '0;
    if (state == S_BUSY) src_ready[grant] = out_free;
  end

  // First requester at or after rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    pick       = rr_ptr;
    pick_found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % NUM_SRC;
      if (!pick_found && src_valid[idx]) begin
        pick       = ID_W'(idx);
        pick_found = 1'b1;
      end
    end
  end

  // A runaway packet is closed by forcing eop on the beat that hits the limit.
  always_comb begin
    ctl_mux = src_ctl[grant];
    if (trunc_now) ctl_mux.eop = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      beat_cnt   <= '0;
      out_valid  <= 1'b0;
      out_ctl    <= '0;
      out_data   <= '0;
      out_src_id <= '0;
      trunc_err  <= 1'b0;
      pkt_count  <= '0;
    end else begin
      trunc_err <= trunc_now;

      if (accept) begin
        out_ctl    <= ctl_mux;
        out_data   <= src_data[grant];
        out_src_id <= grant;
        out_valid  <= 1'b1;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          beat_cnt <= '0;
          if (pick_found) begin
            grant <= pick;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (term_beat) begin
            state     <= S_IDLE;
            rr_ptr    <= next_ptr;
            beat_cnt  <= '0;
            pkt_count <= pkt_count + 32'd1;
          end else if (accept) begin
            beat_cnt  <= beat_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_src_rr_arbiter.sv
// Bench for pkt_src_rr_arbiter: queue-fed sources, a cycle-level rule model
// compared every cycle, and literal expectations per directed scenario.

module tb_pkt_src_rr_arbiter;
  import pkt_src_rr_arbiter_pkg::*;

  localparam int NSRC = 4;
  localparam int MAXB = 4;

  typedef pkt_ctl_default_t  ctl_t;
  typedef pkt_data_default_t data_t;

  typedef struct {
    logic [31:0] payload;
    logic        sop;
    logic        eop;
  } beat_t;

  typedef struct {
    int          src;
    logic [31:0] payload;
    logic        eop;
    int          cyc;
  } log_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NSRC-1:0]      src_valid;
  logic [NSRC-1:0]      src_ready;
  ctl_t  [NSRC-1:0]     src_ctl;
  data_t [NSRC-1:0]     src_data;
  logic                 out_valid;
  logic                 out_ready;
  ctl_t                 out_ctl;
  data_t                out_data;
  logic [1:0]           out_src_id;
  logic                 grant_busy;
  logic                 trunc_err;
  logic [31:0]          pkt_count;

  pkt_src_rr_arbiter #(
    .pkt_data_t (data_t),
    .pkt_ctl_t  (ctl_t),
    .NUM_SRC    (NSRC),
    .MAX_BEATS  (MAXB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_ctl    (src_ctl),
    .src_data   (src_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctl    (out_ctl),
    .out_data   (out_data),
    .out_src_id (out_src_id),
    .grant_busy (grant_busy),
    .trunc_err  (trunc_err),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int trunc_seen = 0;
  log_t lg[$];

  beat_t mem [NSRC][64];
  int    hd [NSRC];
  int    tl [NSRC];
  int    seq [NSRC];
  logic [NSRC-1:0] hs;

  // Model state: owner = -1 means nobody holds the grant.
  int          m_owner = -1;
  int          m_ptr = 0;
  int          m_cnt = 0;
  logic        m_ov = 1'b0;
  ctl_t        m_oc = '0;
  data_t       m_od = '0;
  int          m_oid = 0;
  logic        m_trunc = 1'b0;
  logic [31:0] m_pcnt = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_step();
    logic free;
    logic term;
    logic eop_in;
    logic found;
    int   s;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_ov = 1'b0; m_oc = '0; m_od = '0;
      m_oid = 0; m_trunc = 1'b0; m_pcnt = '0;
    end else begin
      free    = !m_ov || out_ready;
      m_trunc = 1'b0;
      if (m_owner >= 0 && free && src_valid[m_owner]) begin
        m_cnt  = m_cnt + 1;
        eop_in = src_ctl[m_owner].eop;
        m_oc   = src_ctl[m_owner];
        m_od   = src_data[m_owner];
        m_oid  = m_owner;
        m_ov   = 1'b1;
        term   = eop_in || (m_cnt == MAXB);
        if (term && !eop_in) begin
          m_oc.eop = 1'b1;
          m_trunc  = 1'b1;
        end
        if (term) begin
          m_pcnt  = m_pcnt + 1;
          m_ptr   = (m_owner + 1) % NSRC;
          m_owner = -1;
          m_cnt   = 0;
        end
      end else begin
        if (out_ready) m_ov = 1'b0;
        if (m_owner < 0) begin
          found = 1'b0;
          for (int k = 0; k < NSRC; k++) begin
            s = (m_ptr + k) % NSRC;
            if (!found && src_valid[s]) begin
              m_owner = s;
              found   = 1'b1;
            end
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    logic [NSRC-1:0] e_rdy;
    log_t ent;
    @(negedge clk);
    e_rdy = '0;
    if (m_owner >= 0 && (!m_ov || out_ready)) e_rdy[m_owner] = 1'b1;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      ent.src = int'(out_src_id); ent.payload = out_data.payload;
      ent.eop = out_ctl.eop;      ent.cyc = cyc;
      lg.push_back(ent);
    end
    if (trunc_err === 1'b1) trunc_seen++;
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("src_ready", 64'(src_ready), 64'(e_rdy));
    chk("grant_busy", 64'(grant_busy), 64'(m_owner >= 0));
    chk("trunc_err", 64'(trunc_err), 64'(m_trunc));
    chk("pkt_count", 64'(pkt_count), 64'(m_pcnt));
    if (m_ov) begin
      chk("out_src_id", 64'(out_src_id), 64'(m_oid));
      chk("out_ctl", {62'b0, out_ctl}, {62'b0, m_oc});
      chk("out_data", {28'b0, out_data}, {28'b0, m_od});
    end
  end

  task automatic push(input int s, input int n, input logic last_eop);
    for (int i = 0; i < n; i++) begin
      mem[s][tl[s]].payload = (s << 8) | seq[s];
      mem[s][tl[s]].sop     = (i == 0);
      mem[s][tl[s]].eop     = last_eop && (i == n - 1);
      tl[s]++;
      seq[s]++;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NSRC; i++) begin
      if (hd[i] < tl[i]) begin
        src_valid[i]         = 1'b1;
        src_ctl[i].sop       = mem[i][hd[i]].sop;
        src_ctl[i].eop       = mem[i][hd[i]].eop;
        src_data[i].payload  = mem[i][hd[i]].payload;
        src_data[i].flags    = mem[i][hd[i]].payload[3:0];
      end else begin
        src_valid[i] = 1'b0;
        src_ctl[i]   = '0;
        src_data[i]  = '0;
      end
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NSRC; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    drive();
  endtask

  // Handshakes are captured mid-cycle; inputs change 1 time unit after posedge.
  task automatic step();
    @(negedge clk);
    hs = src_valid & src_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NSRC; i++) if (hs[i]) hd[i]++;
    drive();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_src_ready"}, 64'(src_ready), 64'd0);
    chk({tag, "_grant_busy"}, 64'(grant_busy), 64'd0);
    chk({tag, "_trunc_err"}, 64'(trunc_err), 64'd0);
    chk({tag, "_pkt_count"}, 64'(pkt_count), 64'd0);
    chk({tag, "_out_src_id"}, 64'(out_src_id), 64'd0);
    chk({tag, "_out_ctl"}, {62'b0, out_ctl}, 64'd0);
    chk({tag, "_out_data"}, {28'b0, out_data}, 64'd0);
  endtask

  initial begin
    int exp_ord[8];
    logic [31:0] p0;
    out_ready = 1'b1;
    for (int i = 0; i < NSRC; i++) seq[i] = 0;
    clear_queues();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst0");
    rst_n = 1'b1;

    // Sources 0 and 2, three beats each, both pending with rr_ptr at 0.
    lg.delete();
    push(0, 3, 1'b1); push(2, 3, 1'b1); drive();
    repeat (12) step();
    chk("t2_len", 64'(lg.size()), 64'd6);
    exp_ord = '{0, 0, 0, 2, 2, 2, 0, 0};
    for (int i = 0; i < 6 && i < lg.size(); i++) chk("t2_order", 64'(lg[i].src), 64'(exp_ord[i]));
    chk("t2_pkt_count", 64'(pkt_count), 64'd2);

    // rr_ptr must now be 3: source 3 wins over source 0.
    lg.delete();
    push(0, 1, 1'b1); push(3, 1, 1'b1); drive();
    repeat (6) step();
    chk("t2b_len", 64'(lg.size()), 64'd2);
    if (lg.size() >= 2) begin
      chk("t2b_first", 64'(lg[0].src), 64'd3);
      chk("t2b_second", 64'(lg[1].src), 64'd0);
    end
    chk("t2b_pkt_count", 64'(pkt_count), 64'd4);

    // Reset, then all four sources stream single-beat packets.
    rst_n = 1'b0;
    clear_queues();
    repeat (2) step();
    rst_n = 1'b1;
    lg.delete();
    for (int r = 0; r < 2; r++) for (int i = 0; i < NSRC; i++) push(i, 1, 1'b1);
    drive();
    repeat (20) step();
    chk("t3_len", 64'(lg.size()), 64'd8);
    exp_ord = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 8 && i < lg.size(); i++) chk("t3_order", 64'(lg[i].src), 64'(exp_ord[i]));
    for (int i = 1; i < 8 && i < lg.size(); i++) chk("t3_gap", 64'(lg[i].cyc - lg[i-1].cyc), 64'd2);
    chk("t3_pkt_count", 64'(pkt_count), 64'd8);

    // Output stall for 5 cycles with the first beat of source 2 in the out stage.
    lg.delete();
    p0 = (2 << 8) | seq[2];
    push(2, 3, 1'b1); drive();
    repeat (2) step();
    chk("t4_ov", 64'(out_valid), 64'd1);
    out_ready = 1'b0;
    repeat (5) begin
      step();
      chk("t4_hold_valid", 64'(out_valid), 64'd1);
      chk("t4_hold_data", 64'(out_data.payload), 64'(p0));
      chk("t4_hold_rdy", 64'(src_ready), 64'd0);
    end
    out_ready = 1'b1;
    repeat (6) step();
    chk("t4_len", 64'(lg.size()), 64'd3);
    for (int i = 0; i < 3 && i < lg.size(); i++) chk("t4_payload", 64'(lg[i].payload), 64'(p0 + i));
    chk("t4_pkt_count", 64'(pkt_count), 64'd9);

    // Source 1: six beats without eop -> truncated after four.
    lg.delete();
    trunc_seen = 0;
    push(1, 6, 1'b0); drive();
    repeat (10) step();
    chk("t5_len", 64'(lg.size()), 64'd6);
    for (int i = 0; i < 6 && i < lg.size(); i++) begin
      chk("t5_src", 64'(lg[i].src), 64'd1);
      chk("t5_eop", 64'(lg[i].eop), 64'(i == 3));
    end
    chk("t5_trunc_once", 64'(trunc_seen), 64'd1);
    chk("t5_busy_held", 64'(grant_busy), 64'd1);
    chk("t5_pkt_count", 64'(pkt_count), 64'd10);
    // Two more beats: eop lands exactly on beat 4 of the second packet.
    push(1, 2, 1'b1); drive();
    repeat (4) step();
    chk("t5b_len", 64'(lg.size()), 64'd8);
    if (lg.size() >= 8) chk("t5b_eop", 64'(lg[7].eop), 64'd1);
    chk("t5b_no_trunc", 64'(trunc_seen), 64'd1);
    chk("t5b_pkt_count", 64'(pkt_count), 64'd11);

    // Reset during beat 2 of a 5-beat packet.
    lg.delete();
    push(2, 5, 1'b1); drive();
    repeat (3) step();
    chk("t6_mid_busy", 64'(grant_busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    clear_queues();
    repeat (2) step();
    rst_n = 1'b1;
    lg.delete();
    push(1, 1, 1'b1); push(3, 1, 1'b1); drive();
    repeat (6) step();
    chk("t6_len", 64'(lg.size()), 64'd2);
    if (lg.size() >= 2) begin
      chk("t6_first", 64'(lg[0].src), 64'd1);
      chk("t6_second", 64'(lg[1].src), 64'd3);
    end
    chk("t6_pkt_count", 64'(pkt_count), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
